ic_mem_responder: RTL and testbench



---
 rtl/ic_mem_pkg.sv | 32 +++
 rtl/ic_mem_responder_if.sv | 30 +++
 rtl/ic_mem_resp_queue.sv | 87 ++++++++
 rtl/ic_mem_responder.sv | 106 ++++++++++
 tb/tb_ic_mem_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ic_mem_pkg.sv
//============================================================================
// ic_mem_pkg - shared types and data/error helpers for ic_mem_responder.
// Rev 1.0
//============================================================================
`default_nettype none

package ic_mem_pkg;

  localparam int unsigned BUS_SIZE = 32;
  localparam int unsigned AGE_W    = 8;

  typedef struct packed {
    logic [31:0]      addr;
    logic             err;
    logic [AGE_W-1:0] age;
  } ic_mem_resp_t;

  // Upper half is only consumed by 64-bit buses; 32-bit buses truncate it.
  function automatic logic [63:0] ic_mem_data(input logic [31:0] addr,
                                              input logic [31:0] seed);
    return {addr ^ ~seed, addr ^ seed};
  endfunction

  function automatic logic ic_mem_err_hit(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    return (size != 32'd0) && ((addr & ~(size - 32'd1)) == base);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ic_mem_responder_if.sv
//============================================================================
// ic_mem_responder_if - icache fetch bus (req/gnt/rvalid/rdata/err).
// Rev 1.0
//============================================================================
`default_nettype none

interface ic_mem_responder_if #(
  parameter int unsigned BusSize = 32
) ();

  logic               req;
  logic [31:0]        addr;
  logic               gnt;
  logic               rvalid;
  logic [BusSize-1:0] rdata;
  logic               err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );

endinterface

`default_nettype wire

// File: rtl/ic_mem_resp_queue.sv
//============================================================================
// ic_mem_resp_queue - in-order request FIFO with per-entry age counters.
// Rev 1.0
//============================================================================
`default_nettype none

module ic_mem_resp_queue
  import ic_mem_pkg::*;
#(
  parameter int unsigned Depth       = 4,
  parameter int unsigned RespLatency = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [31:0] push_addr_i,
  input  logic        push_err_i,
  input  logic        pop_i,
  output logic        head_ready_o,
  output logic [31:0] head_addr_o,
  output logic        head_err_o,
  output logic [3:0]  count_o
);

  localparam int unsigned      IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AGE_W-1:0] AgeMax   = AGE_W'(RespLatency);
  localparam logic [AGE_W-1:0] AgeReady = AGE_W'(RespLatency - 1);

  // MSB of each pointer is the wrap bit: equal indices + differing wrap = full.
  logic [IdxW:0] wptr_q, rptr_q;
  logic [3:0]    count_q;
  ic_mem_resp_t  mem_q [Depth];
  ic_mem_resp_t  w_head;

  function automatic logic [IdxW:0] ptr_next(input logic [IdxW:0] p);
    if (p[IdxW-1:0] == IdxW'(Depth - 1)) begin
      return {~p[IdxW], {IdxW{1'b0}}};
    end
    return {p[IdxW], p[IdxW-1:0] + 1'b1};
  endfunction

  function automatic ic_mem_resp_t age_step(input ic_mem_resp_t e);
    ic_mem_resp_t r;
    r     = e;
    r.age = (e.age >= AgeMax) ? AgeMax : e.age + 1'b1;
    return r;
  endfunction

  assign w_head       = mem_q[rptr_q[IdxW-1:0]];
  assign head_addr_o  = w_head.addr;
  assign head_err_o   = w_head.err;
  assign head_ready_o = (count_q != 4'd0) && (w_head.age >= AgeReady);
  assign count_o      = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= age_step(mem_q[i]);
      end
      if (push_i) begin
        mem_q[wptr_q[IdxW-1:0]] <= '{addr: push_addr_i, err: push_err_i, age: '0};
        wptr_q                  <= ptr_next(wptr_q);
      end
      if (pop_i) begin
        rptr_q <= ptr_next(rptr_q);
      end
      count_q <= count_q + {3'b000, push_i} - {3'b000, pop_i};
    end
  end

  a_pop_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
    pop_i |-> (count_q != 4'd0));
  a_push_room: assert property (@(posedge clk_i) disable iff (rst_i)
    push_i |-> (count_q < 4'(Depth)));
  a_ptr_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    (count_q == 4'd0) == (wptr_q == rptr_q));

endmodule

`default_nettype wire

// File: rtl/ic_mem_responder.sv
//============================================================================
// ic_mem_responder - memory end of the icache fetch bus; returns in-order,
// address-derived data after a fixed latency, with an error window. Rev 1.0
//============================================================================
`default_nettype none

module ic_mem_responder
  import ic_mem_pkg::*;
#(
  parameter int unsigned BusSize        = BUS_SIZE,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned RespLatency    = 2,
  parameter logic [31:0] DataSeed       = 32'hA5A5_5A5A,
  parameter logic [31:0] ErrBase        = 32'hFFFF_0000,
  parameter logic [31:0] ErrSize        = 32'h0000_1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ic_mem_responder_if.slave   bus,
  input  logic                gnt_stall_i,
  input  logic                resp_stall_i,
  output logic [3:0]          outstanding_o,
  output logic                busy_o
);

  localparam logic [31:0] AlignMask = 32'(BusSize / 8 - 1);

  if (BusSize != 32 && BusSize != 64) begin : g_bad_bus_size
    $error("ic_mem_responder: BusSize must be 32 or 64");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_bad_depth
    $error("ic_mem_responder: MaxOutstanding must be 1..8");
  end
  if (RespLatency < 1 || RespLatency > 255) begin : g_bad_latency
    $error("ic_mem_responder: RespLatency must be 1..255");
  end
  if (ErrSize != 0 && (ErrBase & (ErrSize - 32'd1)) != 0) begin : g_bad_err_base
    $error("ic_mem_responder: ErrBase must be aligned to ErrSize");
  end

  logic               w_gnt, w_accept, w_pop, w_push_err;
  logic               w_head_ready, w_head_err;
  logic [31:0]        w_head_addr;
  logic [3:0]         w_count;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic [BusSize-1:0] rdata_q, rdata_d;

  // Grant looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign w_gnt      = bus.req & ~gnt_stall_i & (w_count < 4'(MaxOutstanding));
  assign w_accept   = bus.req & w_gnt;
  assign w_push_err = ic_mem_err_hit(bus.addr, ErrBase, ErrSize);
  assign w_pop      = w_head_ready & ~resp_stall_i;

  ic_mem_resp_queue #(
    .Depth       (MaxOutstanding),
    .RespLatency (RespLatency)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (w_accept),
    .push_addr_i  (bus.addr),
    .push_err_i   (w_push_err),
    .pop_i        (w_pop),
    .head_ready_o (w_head_ready),
    .head_addr_o  (w_head_addr),
    .head_err_o   (w_head_err),
    .count_o      (w_count)
  );

  always_comb begin
    rvalid_d = w_pop;
    err_d    = w_pop & w_head_err;
    rdata_d  = '0;
    if (w_pop && !w_head_err) begin
      rdata_d = BusSize'(ic_mem_data(w_head_addr, DataSeed));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign outstanding_o = w_count;
  assign busy_o        = (w_count != 4'd0);

  a_no_empty_pop: assert property (@(posedge clk_i) disable iff (rst_i)
    w_pop |-> (w_count != 4'd0));
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    w_accept |-> ((bus.addr & AlignMask) == 32'd0));

endmodule

`default_nettype wire

// File: tb/tb_ic_mem_responder.sv
//============================================================================
// tb_ic_mem_responder - scoreboard bench for ic_mem_responder.
// Rev 1.0
//============================================================================
`default_nettype none

module tb_ic_mem_responder;

  localparam int unsigned c_lat  = 2;
  localparam int unsigned c_max  = 4;
  localparam logic [31:0] c_seed = 32'hA5A5_5A5A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gnt_stall = 1'b0;
  logic       resp_stall = 1'b0;
  logic [3:0] outstanding;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queued requests with ages, plus the outputs expected next cycle.
  logic [31:0] m_addr [$];
  bit          m_err  [$];
  int          m_age  [$];
  bit          e_rvalid = 1'b0;
  logic [31:0] e_rdata  = '0;
  bit          e_err    = 1'b0;

  ic_mem_responder_if #(.BusSize(32)) bus_if ();

  ic_mem_responder #(
    .BusSize        (32),
    .MaxOutstanding (c_max),
    .RespLatency    (c_lat),
    .DataSeed       (c_seed),
    .ErrBase        (32'hFFFF_0000),
    .ErrSize        (32'h0000_1000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus_if),
    .gnt_stall_i   (gnt_stall),
    .resp_stall_i  (resp_stall),
    .outstanding_o (outstanding),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rvalid", 64'(bus_if.rvalid), 64'd0);
      chk("rst_rdata", 64'(bus_if.rdata), 64'd0);
      chk("rst_err", 64'(bus_if.err), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      m_addr.delete();
      m_err.delete();
      m_age.delete();
      e_rvalid = 1'b0;
      e_rdata  = '0;
      e_err    = 1'b0;
    end else begin
      bit          pop, gnt_e, er;
      logic [31:0] a;
      chk("rvalid", 64'(bus_if.rvalid), 64'(e_rvalid));
      chk("rdata", 64'(bus_if.rdata), 64'(e_rdata));
      chk("err", 64'(bus_if.err), 64'(e_err));
      chk("outstanding", 64'(outstanding), 64'(m_addr.size()));
      chk("busy", 64'(busy), 64'(m_addr.size() != 0));
      pop   = (m_addr.size() != 0) && (m_age[0] >= int'(c_lat) - 1) && !resp_stall;
      gnt_e = bus_if.req && !gnt_stall && (m_addr.size() < int'(c_max));
      chk("gnt", 64'(bus_if.gnt), 64'(gnt_e));
      foreach (m_age[i]) m_age[i] = (m_age[i] >= int'(c_lat)) ? int'(c_lat) : m_age[i] + 1;
      e_rvalid = 1'b0;
      e_rdata  = '0;
      e_err    = 1'b0;
      if (pop) begin
        a = m_addr.pop_front();
        er = m_err.pop_front();
        void'(m_age.pop_front());
        e_rvalid = 1'b1;
        e_err    = er;
        e_rdata  = er ? 32'd0 : (a ^ c_seed);
      end
      if (gnt_e) begin
        m_addr.push_back(bus_if.addr);
        m_err.push_back((bus_if.addr & 32'hFFFF_F000) == 32'hFFFF_0000);
        m_age.push_back(0);
      end
    end
  end

  task automatic send(input logic [31:0] a, input bit toggle);
    bit done = 1'b0;
    int n = 0;
    bus_if.req  = 1'b1;
    bus_if.addr = a;
    while (!done && n < 64) begin
      @(negedge clk);
      done = bus_if.gnt;
      @(posedge clk);
      #1;
      if (toggle) gnt_stall = ~gnt_stall;
      n++;
    end
    if (!done) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_addr.size() != 0 || e_rvalid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus_if.req  = 1'b0;
    bus_if.addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch with direct latency and data checks.
    send(32'h0000_0100, 1'b0);
    bus_if.req = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus_if.rvalid) break;
      n++;
    end
    chk("single_latency", 64'(n), 64'(c_lat));
    chk("single_rdata", 64'(bus_if.rdata), 64'hA5A5_5B5A);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back burst beyond the queue depth.
    for (int i = 0; i < 6; i++) send(32'h200 + 32'(4 * i), 1'b0);
    bus_if.req = 1'b0;
    drain();

    // Error window inside / just outside.
    send(32'hFFFF_0040, 1'b0);
    send(32'hFFFF_1000, 1'b0);
    bus_if.req = 1'b0;
    drain();

    // Response stall with three queued.
    resp_stall = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h300 + 32'(4 * i), 1'b0);
    bus_if.req = 1'b0;
    repeat (10) @(posedge clk);
    #1 resp_stall = 1'b0;
    drain();

    // Reset with three outstanding.
    resp_stall = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h400 + 32'(4 * i), 1'b0);
    bus_if.req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    resp_stall = 1'b0;
    #1;
    chk("async_rst_outstanding", 64'(outstanding), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_rvalid", 64'(bus_if.rvalid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send(32'h0000_0500, 1'b0);
    bus_if.req = 1'b0;
    drain();

    // Grant stall toggling every cycle while req is held.
    for (int i = 0; i < 10; i++) send(32'h600 + 32'(4 * i), 1'b1);
    bus_if.req = 1'b0;
    gnt_stall  = 1'b0;
    drain();

    chk("final_outstanding", 64'(outstanding), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
